// File: rtl/ifid_stage.sv
// rtl/ifid_stage.sv - IF/ID pipeline register with load-use hazard, stall and exception flush control
module ifid_stage #(
   parameter int          FLUSH_CYCLES = 2,
   parameter logic [31:0] NOP_WORD     = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] if_instr,
   input  logic [31:0] if_pc,
   input  logic        ex_load,
   input  logic [2:0]  ex_load_rd,
   input  logic        ext_stall,
   input  logic        exc_req,
   output logic [31:0] ifid_instr,
   output logic [31:0] ifid_pc,
   output logic        ifid_valid,
   output logic        pc_write,
   output logic        idex_write,
   output logic        idex_bubble,
   output logic        epc_write,
   output logic        cause_write,
   output logic        flushing
);

   typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;
   typedef enum logic [1:0] {IF_LOAD, IF_HOLD, IF_NOP} ifop_t;

   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

   state_t      state, state_next;
   ifop_t       ifop;
   logic [2:0]  cnt, cnt_next;
   logic        hazard;

   // Both 16-bit halves carry rm at [5:3] and rn at [8:6] of their half.
   assign hazard = ex_load & ifid_valid &
                   ((ifid_instr[5:3]   == ex_load_rd) |
                    (ifid_instr[8:6]   == ex_load_rd) |
                    (ifid_instr[21:19] == ex_load_rd) |
                    (ifid_instr[24:22] == ex_load_rd));

   assign flushing = (state == FLUSH);

   always_comb begin
      state_next  = state;
      cnt_next    = cnt;
      ifop        = IF_LOAD;
      pc_write    = 1'b1;
      idex_write  = 1'b1;
      idex_bubble = 1'b0;
      epc_write   = 1'b0;
      cause_write = 1'b0;
      if (exc_req) begin
         ifop        = IF_NOP;
         idex_bubble = 1'b1;
         epc_write   = 1'b1;
         cause_write = 1'b1;
         cnt_next    = FLUSH_LOAD;
         state_next  = FLUSH;
      end else if (ext_stall) begin
         ifop       = IF_HOLD;
         pc_write   = 1'b0;
         idex_write = 1'b0;
      end else begin
         case (state)
            RUN, STALL: begin
               // A repeated hazard in STALL only arises from a stale ex_load.
               if (hazard) begin
                  ifop        = IF_HOLD;
                  pc_write    = 1'b0;
                  idex_bubble = 1'b1;
                  state_next  = STALL;
               end else begin
                  state_next = RUN;
               end
            end
            FLUSH: begin
               ifop        = IF_NOP;
               idex_bubble = 1'b1;
               if (cnt == 3'd0) state_next = RUN;
               else             cnt_next   = cnt - 3'd1;
            end
            default: state_next = RUN;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= RUN;
         cnt        <= 3'd0;
         ifid_instr <= NOP_WORD;
         ifid_pc    <= 32'd0;
         ifid_valid <= 1'b0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         case (ifop)
            IF_LOAD: begin
               ifid_instr <= if_instr;
               ifid_pc    <= if_pc;
               ifid_valid <= 1'b1;
            end
            // The PC is kept so a squashed slot still reports where the front end stood.
            IF_NOP: begin
               ifid_instr <= NOP_WORD;
               ifid_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ifid_stage.sv
// tb/tb_ifid_stage.sv - directed scoreboard bench for ifid_stage
module tb_ifid_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] if_instr, if_pc;
   logic        ex_load, ext_stall, exc_req;
   logic [2:0]  ex_load_rd;
   logic [31:0] ifid_instr, ifid_pc;
   logic        ifid_valid, pc_write, idex_write, idex_bubble;
   logic        epc_write, cause_write, flushing;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        valid;
      logic [5:0]  ctl;
   } exp_t;

   exp_t sb[$];

   ifid_stage #(.FLUSH_CYCLES(2), .NOP_WORD(32'h0000_0000)) dut (
      .clk(clk), .reset(reset), .if_instr(if_instr), .if_pc(if_pc),
      .ex_load(ex_load), .ex_load_rd(ex_load_rd), .ext_stall(ext_stall), .exc_req(exc_req),
      .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_valid(ifid_valid),
      .pc_write(pc_write), .idex_write(idex_write), .idex_bubble(idex_bubble),
      .epc_write(epc_write), .cause_write(cause_write), .flushing(flushing)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [31:0] i, input logic [31:0] p, input logic v, input logic [5:0] c);
      exp_t e;
      e.instr = i; e.pc = p; e.valid = v; e.ctl = c;
      sb.push_back(e);
   endtask

   // ctl order: {pc_write, idex_write, idex_bubble, epc_write, cause_write, flushing}
   task automatic pop_check(input string tag);
      exp_t e;
      checks++;
      assert (sb.size() > 0) else begin
         errors++;
         $error("FAIL %s observed empty scoreboard expected entry", tag);
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({tag, ".instr"}, ifid_instr, e.instr);
         chk({tag, ".pc"}, ifid_pc, e.pc);
         chk({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, e.valid});
         chk({tag, ".ctl"}, {26'd0, pc_write, idex_write, idex_bubble, epc_write, cause_write, flushing},
             {26'd0, e.ctl});
      end
   endtask

   // Called at a falling edge: drive, check settled outputs, advance past one rising edge.
   task automatic step(input string tag, input logic [31:0] i, input logic [31:0] p,
                       input logic ld, input logic [2:0] rd, input logic st, input logic ex,
                       input logic [31:0] ei, input logic [31:0] ep, input logic ev, input logic [5:0] ec);
      if_instr = i; if_pc = p; ex_load = ld; ex_load_rd = rd; ext_stall = st; exc_req = ex;
      push(ei, ep, ev, ec);
      #1;
      pop_check(tag);
      @(negedge clk);
   endtask

   localparam logic [5:0] NORM  = 6'b110000;
   localparam logic [5:0] HAZ   = 6'b011000;
   localparam logic [5:0] EXC   = 6'b111110;
   localparam logic [5:0] FLSH  = 6'b111001;
   localparam logic [5:0] FRZ   = 6'b000001;

   initial begin
      reset = 1'b1; if_instr = '0; if_pc = '0; ex_load = 0; ex_load_rd = 0; ext_stall = 0; exc_req = 0;
      #2;
      push(32'h0, 32'h0, 1'b0, NORM);
      pop_check("reset");
      @(negedge clk);
      reset = 1'b0;

      step("s1",  32'h1111_2222, 32'h100, 0, 3'd0, 0, 0, 32'h0,         32'h0,   0, NORM);
      step("s2",  32'h0000_0018, 32'h104, 0, 3'd0, 0, 0, 32'h1111_2222, 32'h100, 1, NORM);
      step("haz1",32'h0000_0040, 32'h108, 1, 3'd3, 0, 0, 32'h0000_0018, 32'h104, 1, HAZ);
      step("stl1",32'h0000_0040, 32'h108, 0, 3'd0, 0, 0, 32'h0000_0018, 32'h104, 1, NORM);
      step("noh", 32'h0140_0000, 32'h10C, 0, 3'd5, 0, 0, 32'h0000_0040, 32'h108, 1, NORM);
      step("haz2",32'h5555_0000, 32'h110, 1, 3'd5, 0, 0, 32'h0140_0000, 32'h10C, 1, HAZ);
      step("stl2",32'h5555_0000, 32'h110, 0, 3'd0, 0, 0, 32'h0140_0000, 32'h10C, 1, NORM);
      step("exc1",32'h6666_0000, 32'h114, 0, 3'd0, 0, 1, 32'h5555_0000, 32'h110, 1, EXC);
      step("fl1", 32'h7777_0000, 32'h200, 0, 3'd0, 0, 0, 32'h0,         32'h110, 0, FLSH);
      step("fl2", 32'h7777_0000, 32'h200, 0, 3'd0, 0, 0, 32'h0,         32'h110, 0, FLSH);
      step("run1",32'h7777_0000, 32'h200, 0, 3'd0, 0, 0, 32'h0,         32'h110, 0, NORM);
      step("exc2",32'h8888_0000, 32'h204, 0, 3'd0, 0, 1, 32'h7777_0000, 32'h200, 1, EXC);
      step("frz1",32'h8888_0000, 32'h204, 0, 3'd0, 1, 0, 32'h0,         32'h200, 0, FRZ);
      step("frz2",32'h8888_0000, 32'h204, 0, 3'd0, 1, 0, 32'h0,         32'h200, 0, FRZ);
      step("frz3",32'h8888_0000, 32'h204, 0, 3'd0, 1, 0, 32'h0,         32'h200, 0, FRZ);
      step("fl3", 32'h8888_0000, 32'h204, 0, 3'd0, 0, 0, 32'h0,         32'h200, 0, FLSH);
      step("fl4", 32'h8888_0000, 32'h204, 0, 3'd0, 0, 0, 32'h0,         32'h200, 0, FLSH);
      step("run2",32'h8888_0000, 32'h204, 0, 3'd0, 0, 0, 32'h0,         32'h200, 0, NORM);
      step("all", 32'h9999_0000, 32'h208, 1, 3'd1, 1, 1, 32'h8888_0000, 32'h204, 1, EXC);
      step("fl5", 32'h9999_0000, 32'h208, 0, 3'd0, 0, 0, 32'h0,         32'h204, 0, FLSH);
      if_instr = 32'h9999_0000; if_pc = 32'h208;
      push(32'h0, 32'h204, 1'b0, FLSH);
      #1;
      pop_check("fl6");
      reset = 1'b1;
      push(32'h0, 32'h0, 1'b0, NORM);
      #1;
      pop_check("arst");
      @(negedge clk);
      reset = 1'b0;
      step("post1",32'hAAAA_0000, 32'h300, 0, 3'd0, 0, 0, 32'h0,         32'h0,   0, NORM);
      step("post2",32'hBBBB_0000, 32'h304, 0, 3'd0, 0, 0, 32'hAAAA_0000, 32'h300, 1, NORM);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
